// File: rtl/fifo_out_uart_tx.sv
// Reader end of the output FIFO. It pops 32-bit words and sends them on a UART TX line
// as 8N1 frames, least-significant byte first and LSB-first within each byte.
module fifo_out_uart_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        word_done,
  output logic [15:0] words_sent
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {IDLE, POP, FETCH, START, DATA, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       word_reg;
  logic [7:0]        cur_byte;
  logic              bit_end;

  assign cur_byte   = word_reg[{byte_idx, 3'b000} +: 8];
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign fifo_rd_en = (state == POP);
  assign busy       = (state != IDLE);

  // tx is updated together with the state, so it already holds the level of the
  // state or bit being entered. A start bit therefore appears in the first START cycle.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous. It lives inside the clocked block, and resetn is
    // not in the sensitivity list.
    if (!resetn) begin
      state      <= IDLE;
      tx         <= 1'b1;
      word_done  <= 1'b0;
      words_sent <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      // NOTE: word_reg has no functional need for a reset, because FETCH always loads it
      // before use. Clearing it only keeps the simulation free of X values.
      word_reg   <= '0;
    end else begin
      // NOTE: every state register uses a non-blocking assignment. Each case branch then
      // reads the values from before this edge, such as cur_byte and bit_idx.
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (enable && !fifo_empty) state <= POP;
        end
        POP: state <= FETCH;
        FETCH: begin
          word_reg <= fifo_rd_data;
          byte_idx <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx < BYTE_LAST) begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              word_done  <= 1'b1;
              words_sent <= words_sent + 16'd1;
              state      <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_out_uart_tx.sv
// Self-checking bench for fifo_out_uart_tx. It combines a table of known words, directed
// corner cases and a randomized run, all checked against a frame-level timing model.
module tb_fifo_out_uart_tx;

  localparam int CPB   = 4;
  localparam int BPW   = 4;
  localparam int FRAME = 10 * CPB * BPW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en, tx, busy, word_done;
  logic [15:0] words_sent;

  always #5 clk = ~clk;

  fifo_out_uart_tx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .word_done(word_done), .words_sent(words_sent)
  );

  typedef struct packed {
    logic [31:0]      word;
    logic [3:0][7:0]  bytes;   // bytes[0] is expected on the line first
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_expected = 0;
  logic [31:0] fifo_q[$];
  logic s_rd, s_tx, s_busy, s_wd;
  logic [15:0] s_ws;
  bit cap [FRAME];
  vec_t vecs [4];

  // The model describes each accepted word as a schedule: the pop cycle, the first
  // start-bit cycle and the word_done cycle.
  int exp_pop = -1, exp_start = -1, exp_done = -1, free_at = 0;
  logic [31:0] exp_word = '0;
  logic [15:0] exp_ws = '0;
  bit rst_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_tx(input int c);
    int o, b, p;
    o = c - exp_start;
    b = o / (10 * CPB);
    p = (o % (10 * CPB)) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_word[8 * b + p - 1];
  endfunction

  task automatic model_decide();
    if (!resetn) begin
      rst_pending = 1'b1;
    end else if (cyc >= free_at && enable && fifo_q.size() > 0) begin
      exp_pop   = cyc + 1;
      exp_start = cyc + 3;
      exp_done  = cyc + 3 + FRAME;
      free_at   = exp_done;
      exp_word  = fifo_q[0];
    end
  endtask

  task automatic model_check();
    logic e_rd, e_tx, e_busy, e_wd;
    if (rst_pending) begin
      exp_pop = -1; exp_start = -1; exp_done = -1; free_at = 0;
      exp_ws = '0;
      rst_pending = 1'b0;
    end
    e_wd = (cyc == exp_done);
    if (e_wd) exp_ws = exp_ws + 16'd1;
    e_rd   = (cyc == exp_pop);
    e_busy = (exp_pop >= 0 && cyc >= exp_pop && cyc < exp_done);
    e_tx   = (exp_start >= 0 && cyc >= exp_start && cyc < exp_done) ? model_tx(cyc) : 1'b1;
    check($sformatf("cycle %0d {rd_en,tx,busy,word_done,words_sent}", cyc),
          {s_rd, s_tx, s_busy, s_wd, s_ws}, {e_rd, e_tx, e_busy, e_wd, exp_ws});
  endtask

  task automatic fifo_service();
    if (s_rd) begin
      check("rd_en while FIFO empty", {31'd0, fifo_empty}, 0);
      if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Inputs set before tick() are sampled by the DUT at the next rising edge. The
  // outputs of the resulting cycle are sampled on the falling edge that follows.
  task automatic tick();
    model_decide();
    @(negedge clk);
    cyc++;
    s_rd = fifo_rd_en; s_tx = tx; s_busy = busy; s_wd = word_done; s_ws = words_sent;
    model_check();
    fifo_service();
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!s_rd && n < 30) begin tick(); n++; end
    check(name, {31'd0, s_rd}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rds, wds, d1, st2, bad;
    logic [9:0] fr;

    vecs[0] = '{word: 32'hA5C3_0F12, bytes: {8'hA5, 8'hC3, 8'h0F, 8'h12}};
    vecs[1] = '{word: 32'h0000_0000, bytes: {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{word: 32'hFFFF_FFFF, bytes: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3] = '{word: 32'h8001_7E3C, bytes: {8'h80, 8'h01, 8'h7E, 8'h3C}};

    // Hold reset with a full FIFO and enable set. Nothing may be popped.
    resetn = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h1111_1111 * (i + 1));
    tick(); tick();
    check("reset tx", {31'd0, s_tx}, 1);
    check("reset busy", {31'd0, s_busy}, 0);
    check("reset rd_en", {31'd0, s_rd}, 0);
    check("reset words_sent", {48'd0, s_ws}, 0);
    enable = 1'b0; fifo_q.delete(); fifo_empty = 1'b1;
    resetn = 1'b1;
    tick();

    // Send the known words from the table and decode the line with a bench-side receiver.
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].word); enable = 1'b1;
      wait_rd($sformatf("vec %0d rd_en pulse", v));
      n = 0;
      while (s_tx && n < 10) begin tick(); n++; end
      check($sformatf("vec %0d rd_en to start bit", v), n, 2);
      cap[0] = s_tx; wds = 0;
      for (int i = 1; i < FRAME; i++) begin tick(); cap[i] = s_tx; wds += int'(s_wd); end
      tick();
      words_expected++;
      check($sformatf("vec %0d word_done at +160 only", v), {s_wd, 8'(wds)}, {1'b1, 8'd0});
      check($sformatf("vec %0d words_sent", v), {48'd0, s_ws}, 64'(words_expected));
      for (int b = 0; b < BPW; b++) begin
        for (int k = 0; k < 10; k++) fr[k] = cap[b * 10 * CPB + k * CPB + CPB / 2];
        check($sformatf("vec %0d byte %0d frame", v, b), {54'd0, fr},
              {54'd0, 1'b1, vecs[v].bytes[b], 1'b0});
      end
    end

    // Keep enable high with an empty FIFO. The block must stay idle.
    rds = 0; bad = 0;
    repeat (500) begin
      tick();
      rds += int'(s_rd);
      bad += int'(!s_tx || s_busy);
    end
    check("empty FIFO rd_en count", rds, 0);
    check("empty FIFO tx/busy deviations", bad, 0);

    // Queue two words back to back and measure the idle-high gap between them.
    push($urandom); push($urandom);
    rds = 0; wds = 0; d1 = -1; st2 = -1; n = 0;
    while (wds < 2 && n < 800) begin
      tick(); n++;
      rds += int'(s_rd);
      if (s_wd) begin wds++; if (d1 < 0) d1 = cyc; end
      if (d1 >= 0 && st2 < 0 && !s_tx) st2 = cyc;
    end
    words_expected += 2;
    check("two words rd_en pulses", rds, 2);
    check("two words completed", wds, 2);
    check("inter-word idle-high gap", st2 - d1, 3);
    check("two words words_sent", {48'd0, s_ws}, 64'(words_expected));

    // Drop enable during byte 1. The current word finishes and nothing more is popped.
    push($urandom); push($urandom);
    wait_rd("enable-drop rd_en pulse");
    repeat (60) tick();
    enable = 1'b0;
    n = 0;
    while (!s_wd && n < 300) begin tick(); n++; end
    words_expected++;
    check("enable-drop word_done", {31'd0, s_wd}, 1);
    rds = 0;
    repeat (60) begin tick(); rds += int'(s_rd); end
    check("enable-drop no further pop", rds, 0);
    check("enable-drop FIFO depth", fifo_q.size(), 1);
    check("enable-drop words_sent", {48'd0, s_ws}, 64'(words_expected));
    fifo_q.delete(); fifo_empty = 1'b1;

    // Pulse reset in the middle of a frame, during byte 2 DATA.
    resetn = 1'b0; tick(); resetn = 1'b1;
    words_expected = 0;
    check("reset pulse words_sent", {48'd0, s_ws}, 64'(words_expected));
    push(32'hDEAD_BEEF); enable = 1'b1;
    wait_rd("abort rd_en pulse");
    repeat (94) tick();
    check("abort pre-reset busy", {31'd0, s_busy}, 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    check("abort tx", {31'd0, s_tx}, 1);
    check("abort busy", {31'd0, s_busy}, 0);
    wds = 0;
    repeat (200) begin tick(); wds += int'(s_wd); end
    check("abort no word_done", wds, 0);
    check("abort words_sent", {48'd0, s_ws}, 64'(words_expected));

    // Randomized traffic: pushes, enable toggles and occasional resets.
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0 && fifo_q.size() < 6) push($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      resetn = ($urandom_range(0, 1999) != 0);
      tick();
    end
    resetn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
